matmul_row_seq: RTL
===================

# matmul_row_seq

Sequencer for a one-dimensional row of N multiply-accumulate PEs. It clears the PE accumulators and accepts one operand beat per cycle on a ready/valid port. It feeds the shared A operand into the leftmost PE and skews the per-column B operands to match the PE-to-PE A pipeline. It then drains the N column results out of the leftmost PE through a ready/valid result port. It sits between the DMA/operand buffers and the PE row, computing y[j] = Σk a[k]·b[k][j] for j = 0..N-1.

## Interface
- WORD_SIZE, 16, operand/accumulator width (matches PE)
- N, 4, number of PEs (columns) in the row
- K_W, 8, width of the k_len field
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin an operation; ignored unless idle
- k_len  in  K_W  number of operand beats; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- a_valid  in  1  operand beat valid
- a_ready  out  1  high only in FEED
- a_data  in  WORD_SIZE  a[k]
- b_data  in  N*WORD_SIZE  b[k][j]; column j at bits [j*WORD_SIZE +: WORD_SIZE]
- pe_reset  out  1  to every PE reset
- pe_read  out  1  to every PE read
- pe_a  out  WORD_SIZE  to PE0 l_d_i; registered
- pe_b  out  N*WORD_SIZE  to PE j t_d_i; registered, skewed
- pe_res  in  WORD_SIZE  from PE0 l_d_o
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  WORD_SIZE  y[j], column 0 first
- res_last  out  1  marks y[N-1]

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE: on start, latch k_len and go to CLEAR.
- CLEAR: lasts 1 cycle with pe_reset=1. Next state is FEED if k_len≠0, else FLUSH.
- FEED: a_ready=1. Each a_valid&&a_ready handshake loads pe_a←a_data and pushes b_data into the skew lines, then increments k_cnt. On the beat where k_cnt=k_len-1, go to FLUSH. A cycle without a handshake loads pe_a←0 and pushes zeros, so the bubble contributes a zero product.
- FLUSH: counts N cycles while feeding zeros, then goes to DRAIN.
- DRAIN: res_valid=1, res_data=pe_res, pe_read=res_ready. On each handshake, drain_cnt increments. res_last is high when drain_cnt=N-1. On the last handshake, pulse done and go to IDLE.
- pe_reset = reset | (state==CLEAR).
- Outside FEED, pe_a and every pe_b lane are 0. With these operands zero, PE accumulation during non-read cycles adds 0, so dropping pe_read while res_ready=0 stalls the drain losslessly.
- Skew: column j's B lane is delayed j cycles after pe_a, which matches the j PE-to-PE r_d_o registers. Total delay storage is N(N-1)/2 words.
- Arithmetic is done inside the PEs: the product is truncated to WORD_SIZE and the sum wraps modulo 2^WORD_SIZE. The sequencer does no arithmetic.
- The rightmost PE's r_d_i is tied to 0 at array level, so extra drain reads return 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, a_ready=0, pe_read=0, pe_reset=1 during reset, pe_a=0, pe_b=0, all skew stages=0, res_valid=0, res_last=0, counters=0.
- Reset mid-operation aborts immediately. PE A pipelines may hold stale data, but the B lines are cleared, so stale products are zero.
- Cycle schedule, with start accepted in cycle 0 and a_valid held high:
  - CLEAR in cycle 1.
  - Beats accepted in cycles 2..k_len+1.
  - FLUSH in cycles k_len+2..k_len+N+1.
  - First res_valid in cycle k_len+N+2.
  - With res_ready held high, results arrive one per cycle and done is asserted in cycle k_len+2N+2.
- A beat accepted in cycle t is accumulated in column j at the end of cycle t+1+j.
- start is ignored while busy=1. res_valid holds steady while res_ready=0.

## Structure
- Package matmul_pkg:
  - state enum seq_state_t.
  - Helper function for the bit slice of column j.
- Sub-module skew_line (parameters WORD_SIZE, DEPTH; synchronous clear on reset): a DEPTH-stage shift register. Instantiate it for j=1..N-1; column 0 has no delay.

## Test plan
- N=4, k_len=3, a={1,2,3}, b[k][j]=k+j+1, res_ready=1 → results 14, 20, 26, 32; res_last on 32; done in cycle 13.
- Same data with a_valid toggling 1/0 each cycle → identical results; FLUSH starts one cycle after the 3rd handshake.
- k_len=0 → CLEAR, then FLUSH, then 4 results of 0; done asserted.
- res_ready low for 5 cycles at drain_cnt=1 → pe_read=0 and res_data holds 20 throughout the stall; remaining results are unchanged.
- reset asserted mid-FEED, then a new run with a={2}, b={5,5,5,5} → results 10,10,10,10; nothing leaks from the aborted run.
- start pulsed during DRAIN → ignored; exactly one done pulse; overflow case a=0x100, b=0x100 gives result 0x0000.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the PE-row sequencer.
// Holds the sequencer state encoding and the column slice helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } seq_state_t;

  function automatic int col_lsb(input int j, input int w);
    return j * w;
  endfunction

endpackage

// File: rtl/matmul_row_seq_skew.sv
// Fixed-depth word delay line with synchronous clear.
// Delays one B column to line up with the PE-to-PE A pipeline.
module skew_line #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] i_d,
  output logic [WORD_SIZE-1:0] o_d
);

  logic [WORD_SIZE-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_d = r_sr[DEPTH-1];

endmodule

// File: rtl/matmul_row_seq.sv
// Operand feeder and result drain for a 1-D row of MAC PEs.
// Clears the row, streams skewed operands, then drains column sums.
module matmul_row_seq
  import matmul_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int N         = 4,
  parameter int K_W       = 8
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [WORD_SIZE-1:0]   a_data,
  input  logic [N*WORD_SIZE-1:0] b_data,
  output logic                   pe_reset,
  output logic                   pe_read,
  output logic [WORD_SIZE-1:0]   pe_a,
  output logic [N*WORD_SIZE-1:0] pe_b,
  input  logic [WORD_SIZE-1:0]   pe_res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WORD_SIZE-1:0]   res_data,
  output logic                   res_last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  seq_state_t           r_state, w_next;
  logic [K_W-1:0]       r_klen, r_kcnt;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b    [N];
  logic [WORD_SIZE-1:0] w_lane [N];
  logic                 w_beat, w_res_hs;
  logic                 w_cnt_top, w_last_beat;

  assign w_beat      = a_valid && (r_state == FEED);
  assign w_res_hs    = res_ready && (r_state == DRAIN);
  assign w_cnt_top   = (r_cnt == CW'(N - 1));
  assign w_last_beat = w_beat && (r_kcnt == r_klen - K_W'(1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = (r_klen != '0) ? FEED : FLUSH;
      FEED:    if (w_last_beat) w_next = FLUSH;
      FLUSH:   if (w_cnt_top) w_next = DRAIN;
      DRAIN:   if (w_res_hs && w_cnt_top) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_klen  <= '0;
      r_kcnt  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_res_hs && w_cnt_top;
      if (r_state == IDLE && start) r_klen <= k_len;
      if (r_state != FEED) r_kcnt <= '0;
      else if (w_beat)     r_kcnt <= r_kcnt + K_W'(1);
      // one counter serves both the flush length and the drain index
      if (r_state == FLUSH || w_res_hs)
        r_cnt <= w_cnt_top ? '0 : r_cnt + CW'(1);
      else if (r_state != DRAIN)
        r_cnt <= '0;
    end
  end

  // bubbles and non-FEED cycles inject zeros so PEs add nothing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      for (int j = 0; j < N; j++) r_b[j] <= '0;
    end else begin
      r_a <= w_beat ? a_data : '0;
      for (int j = 0; j < N; j++)
        r_b[j] <= w_beat ? b_data[col_lsb(j, WORD_SIZE) +: WORD_SIZE] : '0;
    end
  end

  assign w_lane[0] = r_b[0];

  for (genvar j = 1; j < N; j++) begin : g_skew
    skew_line #(
      .WORD_SIZE(WORD_SIZE),
      .DEPTH    (j)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .i_d  (r_b[j]),
      .o_d  (w_lane[j])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_pack
    assign pe_b[col_lsb(j, WORD_SIZE) +: WORD_SIZE] = w_lane[j];
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign a_ready   = (r_state == FEED);
  assign pe_reset  = reset | (r_state == CLEAR);
  assign pe_read   = w_res_hs;
  assign pe_a      = r_a;
  assign res_valid = (r_state == DRAIN);
  assign res_data  = pe_res;
  assign res_last  = (r_state == DRAIN) && w_cnt_top;

endmodule
